mem_write_unit: RTL and testbench
=================================

Name: mem_write_unit

Overview:
Write-channel engine that serves the insertion-sort controller. It accepts one (address, data) write request via a start/done handshake and drives it onto the memory's AXI-lite-style AW/W/B channels. It returns the B response to the controller. It sits between the sort controller's write_submodule_start/done/b_resp signals and the memory write port.

Parameters:
ADDR_WDTH, 4, width of the write address.
DATA_WDTH, 32, width of the write data.
RESP_WDTH, 1, width of the B response; 0 means OKAY, any non-zero value means error.
TIMEOUT_CYCLES, 255, maximum cycles spent in WAIT_B before aborting; 0 disables the timeout.

Ports:
clk  input  1  clock.
rst_n  input  1  reset, asynchronous, active-low.
start  input  1  request pulse; addr_in and data_in are sampled when start=1 in IDLE.
addr_in  input  ADDR_WDTH  write address.
data_in  input  DATA_WDTH  write data.
done  output  1  one-cycle pulse when the transaction finishes (completed or timed out).
b_resp  output  RESP_WDTH  captured response; valid when done=1; held until the next accepted start.
timeout  output  1  set together with done when the B wait expired; held until the next accepted start.
busy  output  1  high in every state except IDLE.
aw_valid  output  1  address valid.
aw_ready  input  1  address ready.
aw_addr  output  ADDR_WDTH  registered address.
w_valid  output  1  data valid.
w_ready  input  1  data ready.
w_data  output  DATA_WDTH  registered data.
b_valid  input  1  response valid.
b_ready  output  1  response ready.
b_resp_in  input  RESP_WDTH  response from memory.

Behaviour:
- Reset values: done, busy, aw_valid, w_valid, b_ready and timeout are 0; aw_addr, w_data and b_resp are 0; state is IDLE; aw_sent, w_sent and the timeout counter are 0.
- States: IDLE, SEND, WAIT_B, DONE.
- IDLE:
  - On start=1, register addr_in into aw_addr and data_in into w_data.
  - Clear aw_sent, w_sent, b_resp and timeout.
  - Go to SEND. aw_valid and w_valid rise on the next cycle.
- SEND:
  - aw_valid = !aw_sent and w_valid = !w_sent; both channels are offered concurrently.
  - An AW handshake (aw_valid & aw_ready at a clock edge) sets aw_sent; a W handshake sets w_sent. Both may occur in the same cycle.
  - The valids never drop before their handshake. aw_addr and w_data stay stable while busy.
  - When both flags are set (counting handshakes in the current cycle), go to WAIT_B.
  - Minimum latency: start at cycle 0, SEND at cycle 1, WAIT_B at cycle 2.
- WAIT_B:
  - b_ready=1. The counter increments every cycle.
  - On b_valid=1, capture b_resp_in into b_resp and go to DONE.
  - If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES-1 without b_valid, set timeout=1 and go to DONE; b_resp is forced to all-ones.
  - If b_valid arrives on the expiry cycle, b_valid wins.
- DONE:
  - done=1 for exactly one cycle, then return to IDLE.
  - Best case, done is seen 3 cycles after start (aw_ready, w_ready and b_valid already high).
- B arriving before both AW and W handshakes is ignored, since b_ready=0.
- start while busy is ignored; no queueing.
- Reset mid-transaction: all valid/ready outputs drop asynchronously, the state returns to IDLE, and no done is produced.
- Counter width is clog2(TIMEOUT_CYCLES+1), minimum 1.

Decomposition:
- Shared package holds the state encoding (2-bit: IDLE=0, SEND=1, WAIT_B=2, DONE=3) and the RESP_OKAY=0 constant; the same package carries the sort controller's read/write protocol constants.
- No sub-module is required.

Test Plan:
- Readies held high, addr_in=4'h3, data_in=32'hDEADBEEF, start at cycle 0 -> aw_valid and w_valid high at cycle 1 with aw_addr=3 and w_data=DEADBEEF; b_valid high -> done at cycle 3 with b_resp=0 and timeout=0.
- aw_ready delayed 3 cycles, w_ready immediate -> w_valid drops after 1 cycle; aw_valid is held with a stable aw_addr until its handshake; b_ready rises only after the AW handshake.
- b_resp_in=1 on the B handshake -> b_resp=1 when done pulses, and it is held through IDLE until the next start.
- start pulsed again during SEND with a different addr_in -> ignored; aw_addr is unchanged and exactly one done is produced.
- rst_n asserted during WAIT_B -> b_ready=0 immediately; after release, busy=0 and no done appears.
- TIMEOUT_CYCLES=8, b_valid never asserted -> done with timeout=1 and b_resp=1 exactly 8 cycles after entering WAIT_B.

Source files
------------

// File: rtl/mem_write_unit_pkg.sv
// Shared definitions for the sort controller's memory access engines:
// write-engine state encoding, response codes and read/write protocol constants.
package mem_write_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEND   = 2'd1,
    ST_WAIT_B = 2'd2,
    ST_DONE   = 2'd3
  } wr_state_e;

  localparam int RESP_OKAY = 0;

  // Sort controller read/write protocol constants
  typedef enum logic [1:0] {
    SORT_OP_NONE  = 2'd0,
    SORT_OP_READ  = 2'd1,
    SORT_OP_WRITE = 2'd2
  } sort_op_e;

  localparam int SORT_RD_BEATS = 1;
  localparam int SORT_WR_BEATS = 1;

  // Counter width able to hold 0..limit, never narrower than one bit
  function automatic int cnt_width(input int limit);
    int w;
    w = $clog2(limit + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mem_write_unit_if.sv
// AXI-lite-style write port (AW/W/B) between a write engine (master) and memory (slave).
interface mem_write_unit_if #(
  parameter int ADDR_WDTH = 4,
  parameter int DATA_WDTH = 32,
  parameter int RESP_WDTH = 1
);

  logic                 aw_valid;
  logic                 aw_ready;
  logic [ADDR_WDTH-1:0] aw_addr;
  logic                 w_valid;
  logic                 w_ready;
  logic [DATA_WDTH-1:0] w_data;
  logic                 b_valid;
  logic                 b_ready;
  logic [RESP_WDTH-1:0] b_resp_in;

  modport master (
    output aw_valid, aw_addr, w_valid, w_data, b_ready,
    input  aw_ready, w_ready, b_valid, b_resp_in
  );

  modport slave (
    input  aw_valid, aw_addr, w_valid, w_data, b_ready,
    output aw_ready, w_ready, b_valid, b_resp_in
  );

endinterface

// File: rtl/mem_write_unit.sv
// Single-beat write engine: takes one (addr, data) request from the sort controller,
// drives AW and W concurrently, waits (bounded) for B and reports the response.
module mem_write_unit
  import mem_write_unit_pkg::*;
#(
  parameter int ADDR_WDTH      = 4,
  parameter int DATA_WDTH      = 32,
  parameter int RESP_WDTH      = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WDTH-1:0]  addr_in,
  input  logic [DATA_WDTH-1:0]  data_in,
  output logic                  done,
  output logic [RESP_WDTH-1:0]  b_resp,
  output logic                  timeout,
  output logic                  busy,
  mem_write_unit_if.master      mem
);

  localparam int                CNT_W   = cnt_width(TIMEOUT_CYCLES);
  localparam bit                TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0]  CNT_END = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  wr_state_e             state_reg, state_next;
  logic                  aw_sent_reg, aw_sent_next;
  logic                  w_sent_reg, w_sent_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic [ADDR_WDTH-1:0]  aw_addr_reg, aw_addr_next;
  logic [DATA_WDTH-1:0]  w_data_reg, w_data_next;
  logic [RESP_WDTH-1:0]  b_resp_reg, b_resp_next;
  logic                  timeout_reg, timeout_next;

  logic aw_valid_c, w_valid_c, b_ready_c;
  logic aw_hs, w_hs;

  // Handshake outputs decode straight from state so reset removes them asynchronously
  assign aw_valid_c = (state_reg == ST_SEND) && !aw_sent_reg;
  assign w_valid_c  = (state_reg == ST_SEND) && !w_sent_reg;
  assign b_ready_c  = (state_reg == ST_WAIT_B);
  assign aw_hs      = aw_valid_c && mem.aw_ready;
  assign w_hs       = w_valid_c && mem.w_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      aw_sent_reg <= 1'b0;
      w_sent_reg  <= 1'b0;
      cnt_reg     <= '0;
      aw_addr_reg <= '0;
      w_data_reg  <= '0;
      b_resp_reg  <= '0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      aw_sent_reg <= aw_sent_next;
      w_sent_reg  <= w_sent_next;
      cnt_reg     <= cnt_next;
      aw_addr_reg <= aw_addr_next;
      w_data_reg  <= w_data_next;
      b_resp_reg  <= b_resp_next;
      timeout_reg <= timeout_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    aw_sent_next = aw_sent_reg;
    w_sent_next  = w_sent_reg;
    cnt_next     = cnt_reg;
    aw_addr_next = aw_addr_reg;
    w_data_next  = w_data_reg;
    b_resp_next  = b_resp_reg;
    timeout_next = timeout_reg;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          aw_addr_next = addr_in;
          w_data_next  = data_in;
          aw_sent_next = 1'b0;
          w_sent_next  = 1'b0;
          cnt_next     = '0;
          b_resp_next  = RESP_WDTH'(RESP_OKAY);
          timeout_next = 1'b0;
          state_next   = ST_SEND;
        end
      end

      ST_SEND: begin
        aw_sent_next = aw_sent_reg || aw_hs;
        w_sent_next  = w_sent_reg || w_hs;
        cnt_next     = '0;
        if ((aw_sent_reg || aw_hs) && (w_sent_reg || w_hs)) begin
          state_next = ST_WAIT_B;
        end
      end

      ST_WAIT_B: begin
        cnt_next = cnt_reg + CNT_W'(1);
        // A response arriving on the expiry cycle still counts as a normal completion
        if (mem.b_valid) begin
          b_resp_next = mem.b_resp_in;
          state_next  = ST_DONE;
        end else if (TO_EN && (cnt_reg == CNT_END)) begin
          b_resp_next  = '1;
          timeout_next = 1'b1;
          state_next   = ST_DONE;
        end
      end

      ST_DONE: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign mem.aw_valid = aw_valid_c;
  assign mem.aw_addr  = aw_addr_reg;
  assign mem.w_valid  = w_valid_c;
  assign mem.w_data   = w_data_reg;
  assign mem.b_ready  = b_ready_c;

  assign done    = (state_reg == ST_DONE);
  assign busy    = (state_reg != ST_IDLE);
  assign b_resp  = b_resp_reg;
  assign timeout = timeout_reg;

endmodule

// File: tb/tb_mem_write_unit.sv
// Bench for mem_write_unit: directed scenarios plus randomized transactions checked
// against a cycle-timeline model derived from the handshake/timeout rules.
module tb_mem_write_unit;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int RW = 1;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] addr_in = '0;
  logic [DW-1:0] data_in = '0;
  logic          done;
  logic [RW-1:0] b_resp;
  logic          timeout;
  logic          busy;

  int checks = 0;
  int errors = 0;

  mem_write_unit_if #(.ADDR_WDTH(AW), .DATA_WDTH(DW), .RESP_WDTH(RW)) mem ();

  mem_write_unit #(
    .ADDR_WDTH(AW), .DATA_WDTH(DW), .RESP_WDTH(RW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .addr_in(addr_in), .data_in(data_in),
    .done(done), .b_resp(b_resp), .timeout(timeout), .busy(busy), .mem(mem)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one transaction from the IDLE cycle (t=0) and checks every cycle against a
  // timeline: AW/W handshakes at 1+delay, WAIT_B after both, B or expiry ends it.
  task automatic run_txn(input string name, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int ad, input int wd, input int bd, input logic [RW-1:0] resp,
                         input int glitch_t, input int idle_after);
    int t_aw, t_w, t_b0, t_bv, wait_c, t_done, done_cnt;
    logic exp_to;
    logic [RW-1:0] exp_resp;
    logic [4:0] exp_v, obs_v;
    t_aw = 1 + ad;
    t_w  = 1 + wd;
    t_b0 = ((t_aw > t_w) ? t_aw : t_w) + 1;
    t_bv = (t_b0 > 1 + bd) ? t_b0 : 1 + bd;
    wait_c = t_bv - t_b0;
    if (wait_c <= TO - 1) begin
      exp_to = 1'b0; exp_resp = resp; t_done = t_bv + 1;
    end else begin
      exp_to = 1'b1; exp_resp = '1; t_done = t_b0 + TO;
    end
    done_cnt = 0;
    for (int t = 0; t <= t_done + idle_after; t++) begin
      start         = (t == 0) || (t == glitch_t);
      addr_in       = (t == 0) ? a : ~a;
      data_in       = (t == 0) ? d : ~d;
      mem.aw_ready  = (t >= 1 + ad);
      mem.w_ready   = (t >= 1 + wd);
      mem.b_valid   = (t >= 1 + bd) && (t <= t_done - 1);
      mem.b_resp_in = (t == t_bv) ? resp : ~resp;
      #1;
      exp_v = {(t >= 1 && t <= t_aw), (t >= 1 && t <= t_w), (t >= t_b0 && t < t_done),
               (t == t_done), (t >= 1 && t <= t_done)};
      obs_v = {mem.aw_valid, mem.w_valid, mem.b_ready, done, busy};
      if (done) done_cnt++;
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL %s ctrl t=%0d {awv,wv,brdy,done,busy} got %b expected %b", name, t, obs_v, exp_v);
      end
      if (t >= 1 && t <= t_done) begin
        checks++;
        if (mem.aw_addr !== a || mem.w_data !== d) begin
          errors++;
          $display("FAIL %s payload t=%0d got addr=%h data=%h expected addr=%h data=%h",
                   name, t, mem.aw_addr, mem.w_data, a, d);
        end
      end
      if (t >= 1 && t < t_done) begin
        checks++;
        if (b_resp !== '0 || timeout !== 1'b0) begin
          errors++;
          $display("FAIL %s cleared t=%0d got resp=%0d timeout=%0d expected resp=0 timeout=0",
                   name, t, b_resp, timeout);
        end
      end
      if (t >= t_done) begin
        checks++;
        if (b_resp !== exp_resp || timeout !== exp_to) begin
          errors++;
          $display("FAIL %s result t=%0d got resp=%0d timeout=%0d expected resp=%0d timeout=%0d",
                   name, t, b_resp, timeout, exp_resp, exp_to);
        end
      end
      step();
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL %s done_count got %0d expected 1", name, done_cnt);
    end
    start       = 1'b0;
    mem.b_valid = 1'b0;
    $display("txn %-12s addr=%h data=%h aw_d=%0d w_d=%0d b_d=%0d -> done@%0d resp=%0d timeout=%0d",
             name, a, d, ad, wd, bd, t_done, exp_resp, exp_to);
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({done, busy, timeout, b_resp, mem.aw_valid, mem.w_valid, mem.b_ready} !== '0 ||
        mem.aw_addr !== '0 || mem.w_data !== '0) begin
      errors++;
      $display("FAIL reset_values got done=%b busy=%b to=%b resp=%0d awv=%b wv=%b brdy=%b addr=%h data=%h expected all 0",
               done, busy, timeout, b_resp, mem.aw_valid, mem.w_valid, mem.b_ready, mem.aw_addr, mem.w_data);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    $display("txn reset        outputs checked at reset");
  endtask

  task automatic test_basic();
    run_txn("basic", 4'h3, 32'hDEADBEEF, 0, 0, 0, 1'b0, -1, 1);
  endtask

  task automatic test_aw_delay();
    run_txn("aw_delay", 4'hA, 32'h1234_5678, 3, 0, 0, 1'b0, -1, 1);
  endtask

  task automatic test_error_resp();
    run_txn("error_resp", 4'h7, 32'hCAFE_F00D, 1, 2, 0, 1'b1, -1, 4);
  endtask

  task automatic test_start_while_busy();
    run_txn("start_busy", 4'h9, 32'h0BAD_CAFE, 1, 0, 0, 1'b0, 2, 1);
  endtask

  task automatic test_timeout();
    run_txn("timeout", 4'h5, 32'h5555_AAAA, 0, 0, 100, 1'b0, -1, 1);
    run_txn("b_on_expiry", 4'h6, 32'h6666_0000, 0, 0, 8, 1'b0, -1, 1);
    run_txn("b_after_exp", 4'h8, 32'h8888_0000, 0, 0, 9, 1'b0, -1, 1);
  endtask

  task automatic test_reset_mid();
    start = 1'b1; addr_in = 4'hC; data_in = 32'hC0C0_C0C0;
    mem.aw_ready = 1'b1; mem.w_ready = 1'b1; mem.b_valid = 1'b0; mem.b_resp_in = '0;
    step();
    start = 1'b0;
    step();
    #1;
    checks++;
    if (mem.b_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid pre b_ready got %b expected 1", mem.b_ready);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mem.b_ready, mem.aw_valid, mem.w_valid, busy, done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_mid async {brdy,awv,wv,busy,done} got %b expected 00000",
               {mem.b_ready, mem.aw_valid, mem.w_valid, busy, done});
    end
    step();
    step();
    rst_n = 1'b1;
    mem.b_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || mem.aw_addr !== '0) begin
        errors++;
        $display("FAIL reset_mid after cycle %0d got done=%b busy=%b addr=%h expected 0 0 0",
                 i, done, busy, mem.aw_addr);
      end
      step();
    end
    mem.b_valid = 1'b0;
    $display("txn reset_mid    reset during WAIT_B, no done afterwards");
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      run_txn("random", AW'($urandom), $urandom,
              int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), int'($urandom_range(0, 12)),
              RW'($urandom), int'($urandom_range(1, 3)), int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    mem.aw_ready  = 1'b0;
    mem.w_ready   = 1'b0;
    mem.b_valid   = 1'b0;
    mem.b_resp_in = '0;
    test_reset();
    test_basic();
    test_aw_delay();
    test_error_resp();
    test_start_while_busy();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
